// File: rtl/dmem_arb_pkg.sv
// Shared types and constants for the two-port data-memory arbiter.
// Optional grant statistics are enabled with the DMEM_ARB_STATS_EN macro.
package dmem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } arb_state_t;

  localparam logic PORT_CPU = 1'b0;
  localparam logic PORT_DBG = 1'b1;

  // Wide enough for MEM_LAT-1 with MEM_LAT up to 15.
  localparam int LAT_W = 4;

endpackage

// File: rtl/dmem_arbiter_rr_arb2.sv
// Combinational two-request round-robin picker.
// On a tie, the port that did not win last time is chosen.
module rr_arb2
  import dmem_arb_pkg::*;
(
  input  logic [1:0] req,
  input  logic       last_grant,
  output logic       gnt_valid,
  output logic       gnt_idx
);

  // NOTE: every output of an always_comb gets a default first; a path that
  // skips an assignment would otherwise infer a latch.
  always_comb begin
    gnt_valid = |req;
    gnt_idx   = PORT_CPU;
    unique case (req)
      2'b01:   gnt_idx = PORT_CPU;
      2'b10:   gnt_idx = PORT_DBG;
      2'b11:   gnt_idx = ~last_grant;
      default: gnt_idx = PORT_CPU;
    endcase
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Two-port req/ack arbiter in front of a single-port data memory.
// Define DMEM_ARB_STATS_EN to add per-port saturating grant counters.
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int MEM_LAT = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req0,
  input  logic              we0,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [DATA_W-1:0] wdata0,
  output logic              ack0,
  output logic [DATA_W-1:0] rdata0,
  input  logic              req1,
  input  logic              we1,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata1,
  output logic              ack1,
  output logic [DATA_W-1:0] rdata1,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              owner,
  output logic              busy
`ifdef DMEM_ARB_STATS_EN
  ,
  input  logic              stats_clr,
  output logic [15:0]       gnt_cnt0,
  output logic [15:0]       gnt_cnt1
`endif
);

  localparam logic [LAT_W-1:0] LAT_LOAD = LAT_W'(MEM_LAT - 1);

  arb_state_t        r_state;
  arb_state_t        w_next_state;
  logic              r_last_grant;
  logic [LAT_W-1:0]  r_lat_cnt;
  logic              r_owner;
  logic              r_busy;
  logic              r_mem_en;
  logic              r_mem_we;
  logic [ADDR_W-1:0] r_mem_addr;
  logic [DATA_W-1:0] r_mem_wdata;
  logic              r_ack0;
  logic              r_ack1;
  logic [DATA_W-1:0] r_rdata0;
  logic [DATA_W-1:0] r_rdata1;
  logic              w_gnt_valid;
  logic              w_gnt_idx;

  rr_arb2 u_rr_arb2 (
    .req        ({req1, req0}),
    .last_grant (r_last_grant),
    .gnt_valid  (w_gnt_valid),
    .gnt_idx    (w_gnt_idx)
  );

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    unique case (r_state)
      IDLE:    if (w_gnt_valid) w_next_state = ISSUE;
      ISSUE:   w_next_state = r_mem_we ? RESP : WAIT;
      WAIT:    if (r_lat_cnt == '0) w_next_state = RESP;
      RESP:    w_next_state = IDLE;
      default: w_next_state = IDLE;
    endcase
  end

  // Strobes are derived from the next state so they are clean flop outputs
  // aligned with the state they belong to.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_last_grant <= PORT_DBG;
      r_lat_cnt    <= '0;
      r_owner      <= PORT_CPU;
      r_busy       <= 1'b0;
      r_mem_en     <= 1'b0;
      r_mem_we     <= 1'b0;
      r_mem_addr   <= '0;
      r_mem_wdata  <= '0;
      r_ack0       <= 1'b0;
      r_ack1       <= 1'b0;
      r_rdata0     <= '0;
      r_rdata1     <= '0;
    end else begin
      r_mem_en <= (w_next_state == ISSUE);
      r_busy   <= (w_next_state != IDLE);
      r_ack0   <= (w_next_state == RESP) && (r_owner == PORT_CPU);
      r_ack1   <= (w_next_state == RESP) && (r_owner == PORT_DBG);

      unique case (r_state)
        IDLE: begin
          if (w_gnt_valid) begin
            r_owner      <= w_gnt_idx;
            r_last_grant <= w_gnt_idx;
            r_mem_we     <= (w_gnt_idx == PORT_DBG) ? we1    : we0;
            r_mem_addr   <= (w_gnt_idx == PORT_DBG) ? addr1  : addr0;
            r_mem_wdata  <= (w_gnt_idx == PORT_DBG) ? wdata1 : wdata0;
          end
        end
        ISSUE: r_lat_cnt <= LAT_LOAD;
        WAIT: begin
          if (r_lat_cnt == '0) begin
            if (r_owner == PORT_DBG) r_rdata1 <= mem_rdata;
            else                     r_rdata0 <= mem_rdata;
          end else begin
            r_lat_cnt <= r_lat_cnt - 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign mem_en    = r_mem_en;
  assign mem_we    = r_mem_we;
  assign mem_addr  = r_mem_addr;
  assign mem_wdata = r_mem_wdata;
  assign ack0      = r_ack0;
  assign ack1      = r_ack1;
  assign rdata0    = r_rdata0;
  assign rdata1    = r_rdata1;
  assign owner     = r_owner;
  assign busy      = r_busy;

`ifdef DMEM_ARB_STATS_EN
  logic [15:0] r_gnt_cnt0;
  logic [15:0] r_gnt_cnt1;

  // A clear coinciding with an ISSUE cycle takes priority over the count.
  always_ff @(posedge clk) begin
    if (reset || stats_clr) begin
      r_gnt_cnt0 <= '0;
      r_gnt_cnt1 <= '0;
    end else if (r_state == ISSUE) begin
      if (r_owner == PORT_CPU && r_gnt_cnt0 != 16'hFFFF) r_gnt_cnt0 <= r_gnt_cnt0 + 1'b1;
      if (r_owner == PORT_DBG && r_gnt_cnt1 != 16'hFFFF) r_gnt_cnt1 <= r_gnt_cnt1 + 1'b1;
    end
  end

  assign gnt_cnt0 = r_gnt_cnt0;
  assign gnt_cnt1 = r_gnt_cnt1;
`endif

endmodule

// File: tb/tb_dmem_arbiter.sv
// Randomized bench for dmem_arbiter at MEM_LAT=1 and MEM_LAT=3 against a
// transaction-level model (grant rule, latency formula, shadow memory).
module tb_dmem_arbiter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
  endtask

  function automatic logic [31:0] init_val(input int i);
    return 32'hC0DE_0000 + 32'(i) * 32'h0000_1111;
  endfunction

  for (genvar g = 0; g < 2; g++) begin : g_dut
    localparam int LAT = (g == 0) ? 1 : 3;

    logic        reset;
    logic        req0, we0, ack0, req1, we1, ack1;
    logic [31:0] addr0, wdata0, rdata0, addr1, wdata1, rdata1;
    logic        mem_en, mem_we, owner, busy;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic        stats_clr;
    logic [15:0] gnt_cnt0, gnt_cnt1;
    bit          done = 1'b0;

    dmem_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(LAT)) u_dut (
      .clk       (clk),
      .reset     (reset),
      .req0      (req0),
      .we0       (we0),
      .addr0     (addr0),
      .wdata0    (wdata0),
      .ack0      (ack0),
      .rdata0    (rdata0),
      .req1      (req1),
      .we1       (we1),
      .addr1     (addr1),
      .wdata1    (wdata1),
      .ack1      (ack1),
      .rdata1    (rdata1),
      .mem_en    (mem_en),
      .mem_we    (mem_we),
      .mem_addr  (mem_addr),
      .mem_wdata (mem_wdata),
      .mem_rdata (mem_rdata),
      .owner     (owner),
      .busy      (busy)
`ifdef DMEM_ARB_STATS_EN
      ,
      .stats_clr (stats_clr),
      .gnt_cnt0  (gnt_cnt0),
      .gnt_cnt1  (gnt_cnt1)
`endif
    );

`ifndef DMEM_ARB_STATS_EN
    assign gnt_cnt0 = '0;
    assign gnt_cnt1 = '0;
`endif

    // Memory with LAT-cycle read pipeline; idle slots carry random garbage
    // so a capture on the wrong cycle shows up as bad read data.
    logic [31:0] mem [16];
    logic [31:0] rd_pipe [LAT];
    bit          mem_ready = 1'b0;
    assign mem_rdata = rd_pipe[LAT-1];

    always @(posedge clk) begin
      if (!mem_ready) begin
        for (int i = 0; i < 16; i++) mem[i] <= init_val(i);
        mem_ready <= 1'b1;
      end else if (mem_en && mem_we) begin
        mem[mem_addr[3:0]] <= mem_wdata;
      end
      rd_pipe[0] <= mem_en ? mem[mem_addr[3:0]] : $urandom;
      for (int i = 1; i < LAT; i++) rd_pipe[i] <= rd_pipe[i-1];
    end

    initial begin : stim
      logic [31:0] shadow [16];
      bit          pend [2];
      bit          p_we [2];
      logic [31:0] p_addr [2];
      logic [31:0] p_wdata [2];
      logic [31:0] exp_rd [2];
      int          cnt_model [2];
      int          order [$];
      bit          active, a_port, a_we, last_g;
      logic [31:0] a_addr, a_wdata;
      int          issue_c, ack_c, free_at, n_acks, prob;
      bit          rst_pending, rst_fired, force_both, post_rst_check;
      bit          exp_en, exp_busy, exp_ack0, exp_ack1;
      string       pfx;

      reset = 1'b1;
      stats_clr = 1'b0;
      {req0, we0, req1, we1} = '0;
      {addr0, wdata0, addr1, wdata1} = '0;
      for (int i = 0; i < 16; i++) shadow[i] = init_val(i);
      for (int p = 0; p < 2; p++) begin
        pend[p] = 1'b0; p_we[p] = 1'b0; p_addr[p] = '0; p_wdata[p] = '0;
      end
      active = 1'b0; a_port = 1'b0; a_we = 1'b0; a_addr = '0; a_wdata = '0;
      issue_c = 0; ack_c = 0; free_at = 0; n_acks = 0; last_g = 1'b1;
      rst_pending = 1'b1; rst_fired = 1'b0;
      force_both = 1'b0; post_rst_check = 1'b0;

      for (int cyc = 0; cyc < 650; cyc++) begin
        @(negedge clk);
        pfx = $sformatf("lat%0d c%0d", LAT, cyc);

        if (rst_pending) begin
          check({pfx, " rst mem_en"},    mem_en,    0);
          check({pfx, " rst mem_we"},    mem_we,    0);
          check({pfx, " rst ack0"},      ack0,      0);
          check({pfx, " rst ack1"},      ack1,      0);
          check({pfx, " rst busy"},      busy,      0);
          check({pfx, " rst owner"},     owner,     0);
          check({pfx, " rst mem_addr"},  mem_addr,  0);
          check({pfx, " rst mem_wdata"}, mem_wdata, 0);
          check({pfx, " rst rdata0"},    rdata0,    0);
          check({pfx, " rst rdata1"},    rdata1,    0);
`ifdef DMEM_ARB_STATS_EN
          check({pfx, " rst gnt_cnt0"},  gnt_cnt0,  0);
          check({pfx, " rst gnt_cnt1"},  gnt_cnt1,  0);
`endif
          reset = 1'b0;
          rst_pending = 1'b0;
          active = 1'b0;
          last_g = 1'b1;
          exp_rd[0] = '0; exp_rd[1] = '0;
          cnt_model[0] = 0; cnt_model[1] = 0;
          free_at = cyc;
          force_both = 1'b1;
          post_rst_check = 1'b1;
        end else begin
          exp_en   = active && (cyc == issue_c);
          exp_busy = active && (cyc >= issue_c) && (cyc <= ack_c);
          exp_ack0 = active && (cyc == ack_c) && (a_port == 1'b0);
          exp_ack1 = active && (cyc == ack_c) && (a_port == 1'b1);
          if (active && cyc == ack_c && !a_we) exp_rd[a_port] = shadow[a_addr[3:0]];

          check({pfx, " mem_en"}, mem_en, exp_en);
          check({pfx, " busy"},   busy,   exp_busy);
          check({pfx, " ack0"},   ack0,   exp_ack0);
          check({pfx, " ack1"},   ack1,   exp_ack1);
          check({pfx, " rdata0"}, rdata0, exp_rd[0]);
          check({pfx, " rdata1"}, rdata1, exp_rd[1]);
          if (exp_busy) check({pfx, " owner"}, owner, a_port);
          if (exp_en) begin
            check({pfx, " mem_we"},    mem_we,    a_we);
            check({pfx, " mem_addr"},  mem_addr,  a_addr);
            check({pfx, " mem_wdata"}, mem_wdata, a_wdata);
            if (order.size() < 6) order.push_back(int'(owner));
            if (post_rst_check) begin
              check({pfx, " first grant after reset"}, owner, 0);
              post_rst_check = 1'b0;
            end
          end
          if (active && cyc == ack_c) begin
            active = 1'b0;
            free_at = cyc + 1;
            pend[a_port] = 1'b0;
            n_acks++;
          end
        end

        // Requesters: hold a transaction until acked, then maybe start another.
        prob = (cyc >= 600) ? 0 : ((n_acks < 6) ? 100 : 40);
        for (int p = 0; p < 2; p++) begin
          if (!pend[p] && (force_both || $urandom_range(99) < prob)) begin
            pend[p]    = 1'b1;
            p_we[p]    = 1'($urandom_range(1));
            p_addr[p]  = $urandom;
            p_wdata[p] = $urandom;
          end
        end
        force_both = 1'b0;
        req0 = pend[0]; we0 = p_we[0]; addr0 = p_addr[0]; wdata0 = p_wdata[0];
        req1 = pend[1]; we1 = p_we[1]; addr1 = p_addr[1]; wdata1 = p_wdata[1];

        // Arbiter idle and something pending: it is sampled at the next edge.
        if (!active && cyc >= free_at && (pend[0] || pend[1])) begin
          a_port  = (pend[0] && pend[1]) ? !last_g : pend[1];
          last_g  = a_port;
          active  = 1'b1;
          a_we    = p_we[a_port];
          a_addr  = p_addr[a_port];
          a_wdata = p_wdata[a_port];
          issue_c = cyc + 1;
          ack_c   = cyc + 2 + (a_we ? 0 : LAT);
          if (a_we) shadow[a_addr[3:0]] = a_wdata;
          cnt_model[a_port]++;
        end

        // Abort one read in its first WAIT cycle.
        if (!rst_fired && cyc >= 300 && active && !a_we && cyc == issue_c + 1) begin
          reset = 1'b1;
          rst_pending = 1'b1;
          rst_fired = 1'b1;
        end
      end

      check($sformatf("lat%0d reset during wait happened", LAT), rst_fired, 1);
      check($sformatf("lat%0d contention grants seen", LAT), order.size(), 6);
      for (int i = 0; i < order.size(); i++)
        check($sformatf("lat%0d contention grant %0d", LAT, i), order[i], i % 2);

`ifdef DMEM_ARB_STATS_EN
      check($sformatf("lat%0d gnt_cnt0", LAT), gnt_cnt0, cnt_model[0]);
      check($sformatf("lat%0d gnt_cnt1", LAT), gnt_cnt1, cnt_model[1]);
      stats_clr = 1'b1;
      @(negedge clk);
      stats_clr = 1'b0;
      check($sformatf("lat%0d gnt_cnt0 cleared", LAT), gnt_cnt0, 0);
      check($sformatf("lat%0d gnt_cnt1 cleared", LAT), gnt_cnt1, 0);
`endif
      done = 1'b1;
    end
  end

  initial begin
    for (int i = 0; i < 20000 && !(g_dut[0].done && g_dut[1].done); i++) @(posedge clk);
    check("sequences finished", {g_dut[0].done, g_dut[1].done}, 2'b11);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Shares the single-port data memory between two requesters: port 0 is the CPU load/store path; port 1 is the debug/loader path, used for memory preload and inspection.
- Sits between the requesters and the data memory at the device top level, in the divided CPU clock domain.
- Serialises accesses with a req/ack handshake and round-robin arbitration, and returns read data to the owning port.

Parameters:
- ADDR_W, 32, address width on all ports.
- DATA_W, 32, data width on all ports.
- MEM_LAT, 1, read latency in cycles from the mem_en cycle to mem_rdata valid; must be 1..15.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  synchronous, active-high.
- req0  in  1  port 0 (CPU) request; held until ack0.
- we0  in  1  port 0 write enable; 1 = store, 0 = load.
- addr0  in  ADDR_W  port 0 address.
- wdata0  in  DATA_W  port 0 store data.
- ack0  out  1  port 0 completion, one-cycle pulse.
- rdata0  out  DATA_W  port 0 load data; valid while ack0=1.
- req1, we1, addr1, wdata1, ack1, rdata1: same as port 0, for port 1 (debug/loader).
- mem_en  out  1  memory access strobe, one cycle per access.
- mem_we  out  1  memory write enable, qualified by mem_en.
- mem_addr  out  ADDR_W  memory address.
- mem_wdata  out  DATA_W  memory write data.
- mem_rdata  in  DATA_W  memory read data, valid MEM_LAT cycles after mem_en.
- owner  out  1  port currently granted; valid when busy=1.
- busy  out  1  1 in any state other than IDLE.

Behaviour:
- Clock and reset: clk drives all state; reset is synchronous, active-high.
- Reset values:
  - state=IDLE.
  - mem_en, mem_we, ack0, ack1, busy = 0.
  - mem_addr, mem_wdata, rdata0, rdata1, owner = 0.
  - last_grant=1, so port 0 wins the first tie.
- Handshake rules:
  - A requester holds req, we, addr and wdata stable until it sees its ack.
  - ack is a registered one-cycle pulse.
  - A req still high in the cycle after ack counts as a new request.
  - Dropping req before ack is illegal; the arbiter completes the access regardless.
- State machine (IDLE, ISSUE, WAIT, RESP):
  - IDLE: sample req0/req1.
    - Neither high: stay in IDLE.
    - Only one high: grant that port.
    - Both high: grant ~last_grant.
    - On a grant: latch the winner's we/addr/wdata into mem_*, set owner and last_grant, go to ISSUE.
  - ISSUE: mem_en=1 for exactly this cycle.
    - Write: go to RESP.
    - Read: load the latency counter with MEM_LAT-1 and go to WAIT; with MEM_LAT=1 the counter is already 0 and WAIT lasts one cycle.
  - WAIT: decrement the counter. At counter==0, capture mem_rdata into rdata[owner] and go to RESP.
  - RESP: ack[owner]=1 for one cycle; go to IDLE.
- Latency, with req sampled at edge N:
  - mem_en is high in cycle N+1.
  - Write ack is high in cycle N+2.
  - Read ack is high in cycle N+2+MEM_LAT.
- Fairness:
  - The arbiter returns to IDLE between accesses, so no port is starved.
  - Under continuous contention, grants alternate 0,1,0,1.
- Data holding:
  - rdata of the non-owner port holds its old value.
  - rdata[owner] holds the captured value until that port's next read completes.
  - On a write, rdata[owner] is unchanged.
- Simultaneous events: a new req arriving while busy is ignored until IDLE; the request is not queued.
- Reset mid-operation: the arbiter aborts to IDLE immediately, with no ack and mem_en=0 in the next cycle. A write already strobed may have committed.
- Width rules: addresses and data pass through unmodified; there is no address decode.

Optional Feature:
- Macro: DMEM_ARB_STATS_EN.
- Defined:
  - Adds outputs gnt_cnt0 and gnt_cnt1 (16 bits each) and an input stats_clr (1 bit).
  - Each counter increments in the ISSUE cycle of its port.
  - Counters saturate at 16'hFFFF.
  - Counters are cleared by reset or by stats_clr=1. When stats_clr=1 coincides with ISSUE, the clear wins.
- Undefined: the counters and stats_clr are absent, and arbitration behaviour is identical.

Decomposition:
- Package dmem_arb_pkg holds:
  - the state enum (IDLE, ISSUE, WAIT, RESP);
  - constants PORT_CPU=0 and PORT_DBG=1;
  - the latency-counter width constant LAT_W=4.
- Sub-module rr_arb2: a combinational two-request round-robin picker. Inputs: req[1:0], last_grant. Outputs: gnt_valid, gnt_idx.

Test Plan:
- Single CPU read: MEM_LAT=1, mem[0x10]=0xDEADBEEF; req0=1, we0=0, addr0=0x10 at edge N -> mem_en in cycle N+1, ack0 in cycle N+3 with rdata0=0xDEADBEEF; ack1 stays 0.
- Single debug write: req1=1, we1=1, addr1=0x20, wdata1=0x12345678 -> mem_en=1, mem_we=1, mem_addr=0x20 in cycle N+1; ack1 in cycle N+2; a following port 0 read of 0x20 returns 0x12345678.
- Contention: req0 and req1 held high for 6 accesses straight out of reset -> grant order 0,1,0,1,0,1; each ack is a single-cycle pulse.
- Latency sweep: MEM_LAT=3, read -> ack0 exactly 5 cycles after the sampling edge; mem_en high for exactly 1 cycle.
- Reset mid-access: assert reset during WAIT -> next cycle state=IDLE, busy=0, ack0=0, last_grant=1; a subsequent request completes normally.
- Stats (DMEM_ARB_STATS_EN): 3 port 0 and 2 port 1 accesses -> gnt_cnt0=3, gnt_cnt1=2; pulse stats_clr -> both counters 0.
